// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command queue: field widths, the packed
// command layout, the command type encoding and the queue FSM state codes.
package gpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int OFS_W   = 16;
  localparam int IMG_W   = 16;
  localparam int COLOR_W = 16;
  localparam int DEF_XW  = 11;
  localparam int DEF_YW  = 10;

  function automatic int cmd_bits(input int xw, input int yw);
    return 1 + ADDR_W + 2 * OFS_W + IMG_W + 2 * xw + 2 * yw + COLOR_W;
  endfunction

  localparam int CMD_W = cmd_bits(DEF_XW, DEF_YW);

  typedef enum logic {
    CMD_DRAW  = 1'b0,
    CMD_CLEAR = 1'b1
  } cmd_type_e;

  // Field order is the bit order used by the queue when packing a command.
  typedef struct packed {
    cmd_type_e            kind;
    logic [ADDR_W-1:0]    address;
    logic [OFS_W-1:0]     address_x;
    logic [OFS_W-1:0]     address_y;
    logic [IMG_W-1:0]     image_width;
    logic [DEF_XW-1:0]    width;
    logic [DEF_YW-1:0]    height;
    logic [DEF_XW-1:0]    x;
    logic [DEF_YW-1:0]    y;
    logic [COLOR_W-1:0]   clear_color;
  } gpu_cmd_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_STROBE    = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

endpackage

// File: rtl/gpu_cmd_queue_if.sv
// Command intake and GPU control bundle between a producer/GPU pair and the queue.
interface gpu_cmd_queue_if #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
);
  import gpu_pkg::*;

  localparam int XW = $clog2(FB_WIDTH) + 2;
  localparam int YW = $clog2(FB_HEIGHT) + 2;

  // A command transfers on a rising clk edge where cmd_valid and cmd_ready are
  // both 1; once raised, cmd_valid and the cmd_* fields hold until that edge.
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_is_clear;
  logic [ADDR_W-1:0]  cmd_address;
  logic [OFS_W-1:0]   cmd_address_x;
  logic [OFS_W-1:0]   cmd_address_y;
  logic [IMG_W-1:0]   cmd_image_width;
  logic [XW-1:0]      cmd_width;
  logic [YW-1:0]      cmd_height;
  logic [XW-1:0]      cmd_x;
  logic [YW-1:0]      cmd_y;
  logic [COLOR_W-1:0] cmd_clear_color;

  logic [ADDR_W-1:0]  ctrl_address;
  logic [OFS_W-1:0]   ctrl_address_x;
  logic [OFS_W-1:0]   ctrl_address_y;
  logic [IMG_W-1:0]   ctrl_image_width;
  logic [XW-1:0]      ctrl_width;
  logic [YW-1:0]      ctrl_height;
  logic [XW-1:0]      ctrl_x;
  logic [YW-1:0]      ctrl_y;
  logic [COLOR_W-1:0] ctrl_clear_color;
  logic               ctrl_draw;
  logic               ctrl_clear;
  logic               ctrl_busy;

  modport slave (
    input  cmd_valid, cmd_is_clear, cmd_address, cmd_address_x, cmd_address_y,
           cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color,
           ctrl_busy,
    output cmd_ready, ctrl_address, ctrl_address_x, ctrl_address_y,
           ctrl_image_width, ctrl_width, ctrl_height, ctrl_x, ctrl_y,
           ctrl_clear_color, ctrl_draw, ctrl_clear
  );

  modport master (
    output cmd_valid, cmd_is_clear, cmd_address, cmd_address_x, cmd_address_y,
           cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color,
           ctrl_busy,
    input  cmd_ready, ctrl_address, ctrl_address_x, ctrl_address_y,
           ctrl_image_width, ctrl_width, ctrl_height, ctrl_x, ctrl_y,
           ctrl_clear_color, ctrl_draw, ctrl_clear
  );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// Command storage: power-of-two FIFO with a registered read port and a fill level.
module gpu_cmd_fifo #(
  parameter int WIDTH = 139,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // rd_data is only loaded on a pop, so it doubles as the issue holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Buffers draw/clear commands and issues them one at a time to the GPU with a
// setup cycle, a single strobe cycle, and a busy/done handshake with timeout.
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH     = 400,
  parameter int FB_HEIGHT    = 240,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gpu_cmd_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle,
  output logic [15:0]             done_count,
  output logic                    timeout_err,
  output logic [2:0]              dbg_state
);

  localparam int XW = $clog2(FB_WIDTH) + 2;
  localparam int YW = $clog2(FB_HEIGHT) + 2;
  localparam int CW = cmd_bits(XW, YW);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(BUSY_TIMEOUT - 1);

  logic [2:0]    state;
  logic [TW-1:0] wait_cnt;
  logic [1:0]    run_sync;
  logic          run;
  logic          push;
  logic          pop;
  logic [CW-1:0] cmd_in;
  logic [CW-1:0] head;
  logic          head_is_clear;

  assign bus.cmd_ready = (level != FULL_LEVEL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign run           = run_sync[1];
  assign pop           = (state == ST_IDLE) && run && (level != '0);

  assign cmd_in = {bus.cmd_is_clear, bus.cmd_address, bus.cmd_address_x,
                   bus.cmd_address_y, bus.cmd_image_width, bus.cmd_width,
                   bus.cmd_height, bus.cmd_x, bus.cmd_y, bus.cmd_clear_color};

  gpu_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (cmd_in),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level)
  );

  assign {head_is_clear, bus.ctrl_address, bus.ctrl_address_x, bus.ctrl_address_y,
          bus.ctrl_image_width, bus.ctrl_width, bus.ctrl_height, bus.ctrl_x,
          bus.ctrl_y, bus.ctrl_clear_color} = head;

  // Issue is held off until reset release has passed through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_sync <= 2'b00;
    else        run_sync <= {run_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      done_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) state <= ST_SETUP;
        end
        ST_SETUP: begin
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          state    <= ST_WAIT_BUSY;
          wait_cnt <= '0;
        end
        ST_WAIT_BUSY: begin
          if (bus.ctrl_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            // GPU never acknowledged: retire the command so the queue keeps draining.
            timeout_err <= 1'b1;
            done_count  <= done_count + 16'd1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.ctrl_busy) begin
            done_count <= done_count + 16'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ctrl_draw  = (state == ST_STROBE) && (head_is_clear == CMD_DRAW);
  assign bus.ctrl_clear = (state == ST_STROBE) && (head_is_clear == CMD_CLEAR);
  assign idle           = (state == ST_IDLE) && (level == '0);
  assign dbg_state      = state;

endmodule
